// File: rtl/boolfuck_pkg.sv
// Shared types and channel map for the boolfuck input conditioning block.
// Raw channels are packed as {ctl, rgt, lft, key[7:0]}.
package boolfuck_pkg;

    typedef enum logic [1:0] {
        KS_IDLE = 2'b00,
        KS_ONE  = 2'b01,
        KS_LOCK = 2'b10
    } kst_t;

    localparam int NUM_CH = 11;
    localparam int CH_LFT = 8;
    localparam int CH_RGT = 9;
    localparam int CH_CTL = 10;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/boolfuck_input_if.sv
// Raw board inputs and conditioned level outputs of boolfuck_input.
// Plain levels, no handshake: every signal is sampled on each clock edge.
interface boolfuck_input_if;
    import boolfuck_pkg::*;

    logic       lft_i;
    logic       rgt_i;
    logic       ctl_i;
    logic [7:0] key_i;
    logic       lft;
    logic       rgt;
    logic       ctl;
    logic [7:0] key;
    kst_t       kst;

    modport master (
        output lft_i, rgt_i, ctl_i, key_i,
        input  lft, rgt, ctl, key, kst
    );

    modport slave (
        input  lft_i, rgt_i, ctl_i, key_i,
        output lft, rgt, ctl, key, kst
    );

endinterface

// File: rtl/boolfuck_debounce.sv
// One input channel: SYNC-stage synchroniser, then a level is accepted only after
// it differs from the stable level for DB_CYCLES consecutive cycles.
module boolfuck_debounce #(
    parameter int SYNC      = 2,
    parameter int DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [SYNC-1:0] sync;
    logic [CW-1:0]   cnt;
    logic            y;

    assign y = sync[SYNC-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync <= {sync[SYNC-2:0], raw};
            // Any sample that agrees with the stable level restarts qualification.
            if (y == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                stable <= y;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/boolfuck_input.sv
// Conditions buttons and key switches for the interpreter: debounce every channel,
// add auto-repeat gaps on lft/rgt, and let only single keys through to key.
module boolfuck_input
    import boolfuck_pkg::*;
#(
    parameter int SYNC      = 2,
    parameter int DB_CYCLES = 250000,
    parameter int RPT_DELAY = 25000000,
    parameter int RPT_RATE  = 5000000
) (
    input logic              clk,
    input logic              rst,
    boolfuck_input_if.slave  bus
);

    localparam int HW = $clog2(RPT_DELAY + 1);
    localparam int RW = $clog2(RPT_RATE);

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] stable;
    logic [1:0]        rep_s;
    logic [1:0]        rep_q;
    logic              ctl_q;
    logic [7:0]        k;
    logic [3:0]        n;
    kst_t              state, state_n;
    logic [7:0]        key_q, key_n;

    assign raw = {bus.ctl_i, bus.rgt_i, bus.lft_i, bus.key_i};

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_db
        boolfuck_debounce #(
            .SYNC      (SYNC),
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .raw    (raw[ch]),
            .stable (stable[ch])
        );
    end

    assign rep_s = {stable[CH_RGT], stable[CH_LFT]};

    // h saturates at RPT_DELAY; from then r reloads every RPT_RATE cycles, gap at r == 0.
    for (genvar i = 0; i < 2; i++) begin : g_rpt
        logic [HW-1:0] h;
        logic [RW-1:0] r;
        logic          gap;
        logic          q;

        assign gap      = (h == HW'(RPT_DELAY)) && (r == '0);
        assign rep_q[i] = q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                h <= '0;
                r <= '0;
                q <= 1'b0;
            end else begin
                q <= rep_s[i] & ~gap;
                if (!rep_s[i]) begin
                    h <= '0;
                    r <= '0;
                end else if (h != HW'(RPT_DELAY)) begin
                    h <= h + 1'b1;
                end else if (r == RW'(RPT_RATE - 1)) begin
                    r <= '0;
                end else begin
                    r <= r + 1'b1;
                end
            end
        end
    end

    assign k = stable[7:0];
    assign n = popcount8(k);

    // key_q doubles as the latched single key while in KS_ONE.
    always_comb begin
        state_n = state;
        key_n   = key_q;
        case (state)
            KS_IDLE: begin
                key_n = '0;
                if (n == 4'd1) begin
                    state_n = KS_ONE;
                    key_n   = k;
                end else if (n > 4'd1) begin
                    state_n = KS_LOCK;
                end
            end
            KS_ONE: begin
                if (k == '0) begin
                    state_n = KS_IDLE;
                    key_n   = '0;
                end else if (k != key_q) begin
                    state_n = KS_LOCK;
                    key_n   = '0;
                end
            end
            KS_LOCK: begin
                key_n = '0;
                if (k == '0) state_n = KS_IDLE;
            end
            default: begin
                state_n = KS_IDLE;
                key_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= KS_IDLE;
            key_q <= '0;
            ctl_q <= 1'b0;
        end else begin
            state <= state_n;
            key_q <= key_n;
            ctl_q <= stable[CH_CTL];
        end
    end

    assign bus.lft = rep_q[0];
    assign bus.rgt = rep_q[1];
    assign bus.ctl = ctl_q;
    assign bus.key = key_q;
    assign bus.kst = state;

endmodule

// File: tb/tb_boolfuck_input.sv
// Directed bench for boolfuck_input with SYNC=2, DB_CYCLES=4, RPT_DELAY=8, RPT_RATE=3.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same offset.
module tb_boolfuck_input;
    import boolfuck_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    boolfuck_input_if bus();

    boolfuck_input #(
        .SYNC      (2),
        .DB_CYCLES (4),
        .RPT_DELAY (8),
        .RPT_RATE  (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int cnt);
        for (int i = 0; i < cnt; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_bit;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.lft_i = 1'b0;
        bus.rgt_i = 1'b0;
        bus.ctl_i = 1'b0;
        bus.key_i = 8'h00;

        // Reset state
        tick_n(3);
        chk("reset_lft", {7'b0, bus.lft}, 8'h00);
        chk("reset_rgt", {7'b0, bus.rgt}, 8'h00);
        chk("reset_ctl", {7'b0, bus.ctl}, 8'h00);
        chk("reset_key", bus.key, 8'h00);
        chk("reset_kst", {6'b0, bus.kst}, {6'b0, KS_IDLE});
        rst = 1'b0;
        tick_n(2);

        // Clean press: lft rises exactly at edge 7
        bus.lft_i = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("press_early", {7'b0, bus.lft}, 8'h00);
        end
        tick();
        chk("press_edge7", {7'b0, bus.lft}, 8'h01);
        chk("press_rgt_quiet", {7'b0, bus.rgt}, 8'h00);
        chk("press_ctl_quiet", {7'b0, bus.ctl}, 8'h00);
        tick_n(13);
        bus.lft_i = 1'b0;
        tick_n(10);
        chk("press_release", {7'b0, bus.lft}, 8'h00);

        // Bounce filter on key 3
        for (int rep = 0; rep < 5; rep++) begin
            bus.key_i = 8'h08;
            for (int j = 0; j < 3; j++) begin
                tick();
                chk("bounce_hi", bus.key, 8'h00);
            end
            bus.key_i = 8'h00;
            tick();
            chk("bounce_lo", bus.key, 8'h00);
        end
        bus.key_i = 8'h08;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("bounce_settle", bus.key, 8'h00);
        end
        tick();
        chk("bounce_key", bus.key, 8'h08);
        chk("bounce_kst", {6'b0, bus.kst}, {6'b0, KS_ONE});
        bus.key_i = 8'h00;
        tick_n(10);
        chk("bounce_release_key", bus.key, 8'h00);
        chk("bounce_release_kst", {6'b0, bus.kst}, {6'b0, KS_IDLE});

        // Chord: 01 -> 03 -> 02 -> 00
        bus.key_i = 8'h01;
        tick_n(6);
        chk("chord_pre", bus.key, 8'h00);
        tick();
        chk("chord_one", bus.key, 8'h01);
        bus.key_i = 8'h03;
        tick_n(6);
        chk("chord_hold_one", bus.key, 8'h01);
        tick();
        chk("chord_lock_key", bus.key, 8'h00);
        chk("chord_lock_kst", {6'b0, bus.kst}, {6'b0, KS_LOCK});
        bus.key_i = 8'h02;
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("chord_partial_key", bus.key, 8'h00);
        end
        chk("chord_partial_kst", {6'b0, bus.kst}, {6'b0, KS_LOCK});
        bus.key_i = 8'h00;
        tick_n(10);
        chk("chord_end_key", bus.key, 8'h00);
        chk("chord_end_kst", {6'b0, bus.kst}, {6'b0, KS_IDLE});

        // Simultaneous swap 04 -> 10
        bus.key_i = 8'h04;
        tick_n(7);
        chk("swap_first", bus.key, 8'h04);
        bus.key_i = 8'h10;
        tick_n(7);
        chk("swap_lock_key", bus.key, 8'h00);
        chk("swap_lock_kst", {6'b0, bus.kst}, {6'b0, KS_LOCK});
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("swap_never_10", bus.key, 8'h00);
        end
        bus.key_i = 8'h00;
        tick_n(10);
        chk("swap_end_kst", {6'b0, bus.kst}, {6'b0, KS_IDLE});

        // Auto-repeat on rgt: raw held for 20 edges, rgt rises at E = edge 7
        bus.rgt_i = 1'b1;
        tick_n(7);
        chk("rpt_rise", {7'b0, bus.rgt}, 8'h01);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 13) bus.rgt_i = 1'b0;
            exp_bit = !(k == 8 || k == 11 || k == 14 || k == 17 || k == 20);
            chk($sformatf("rpt_E+%0d", k), {7'b0, bus.rgt}, {7'b0, exp_bit});
        end
        chk("rpt_lft_quiet", {7'b0, bus.lft}, 8'h00);
        tick_n(5);
        chk("rpt_released", {7'b0, bus.rgt}, 8'h00);

        // Reset during a held ctl
        bus.ctl_i = 1'b1;
        tick_n(6);
        chk("rst_ctl_pre", {7'b0, bus.ctl}, 8'h00);
        tick();
        chk("rst_ctl_up", {7'b0, bus.ctl}, 8'h01);
        rst = 1'b1;
        #1;
        chk("rst_ctl_async", {7'b0, bus.ctl}, 8'h00);
        tick_n(2);
        chk("rst_ctl_held", {7'b0, bus.ctl}, 8'h00);
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("rst_requalify", {7'b0, bus.ctl}, 8'h00);
        end
        tick();
        chk("rst_ctl_again", {7'b0, bus.ctl}, 8'h01);
        bus.ctl_i = 1'b0;
        tick_n(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
